// File: rtl/inst_encoder_loader.sv
// Encodes RV64 instruction descriptors into 32-bit words and streams them into IMEM
// at consecutive word addresses through a two-stage (capture, encode) pipeline.
module inst_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_start,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  out_we,
  input  logic                  in_mem_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH:0]   out_count,
  output logic                  out_full,
  output logic                  out_err
);

  typedef enum logic {RUN, FULL} state_t;

  localparam logic [ADDR_WIDTH+1:0] CAP  = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LAST = (ADDR_WIDTH+1)'(CAP - 1'b1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t state;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;

  logic [31:0] enc_inst;
  logic        enc_bad;
  logic        imm_ok_11;
  logic        imm_ok_12;
  logic        imm_ok_20;
  logic        is_shift;

  logic                  wr_done;
  logic                  s2_free;
  logic                  s1_adv;
  logic                  accept;
  logic [ADDR_WIDTH+1:0] pending;

  always_comb begin
    enc_inst  = '0;
    enc_bad   = 1'b0;
    imm_ok_11 = (s1_imm[31:11] == '0) || (s1_imm[31:11] == '1);
    imm_ok_12 = (s1_imm[31:12] == '0) || (s1_imm[31:12] == '1);
    imm_ok_20 = (s1_imm[31:20] == '0) || (s1_imm[31:20] == '1);
    is_shift  = (s1_opcode == 7'b0010011) && ((s1_funct3 == 3'b001) || (s1_funct3 == 3'b101));
    case (s1_fmt)
      3'd0: enc_inst = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      3'd1: begin
        if (is_shift)
          enc_inst = {s1_funct7[6:1], s1_imm[5:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        else
          enc_inst = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_bad = !imm_ok_11;
      end
      3'd2: begin
        enc_inst = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_bad  = !imm_ok_11;
      end
      3'd3: begin
        enc_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                    s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_bad  = !imm_ok_12 || s1_imm[0];
      end
      3'd4: enc_inst = {s1_imm[31:12], s1_rd, s1_opcode};
      3'd5: begin
        enc_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        enc_bad  = !imm_ok_20 || s1_imm[0];
      end
      default: enc_bad = 1'b1;
    endcase
    if (s1_opcode[1:0] != 2'b11) enc_bad = 1'b1;
  end

  // Words already written plus words in flight must never exceed IMEM capacity;
  // an illegal entry in S1 is counted conservatively until it is dropped.
  always_comb begin
    wr_done   = out_we && in_mem_ready;
    s2_free   = !out_we || in_mem_ready;
    s1_adv    = s1_valid && s2_free;
    pending   = {1'b0, out_count} + (ADDR_WIDTH+2)'(s1_valid) + (ADDR_WIDTH+2)'(out_we);
    out_ready = in_start ||
                ((state == RUN) && (!s1_valid || s2_free) && (pending < CAP));
    accept    = in_valid && out_ready;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state     <= RUN;
      s1_valid  <= 1'b0;
      s1_fmt    <= '0;
      s1_opcode <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
      out_we    <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE;
      out_count <= '0;
      out_full  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        s1_fmt    <= in_fmt;
        s1_opcode <= in_opcode;
        s1_funct3 <= in_funct3;
        s1_funct7 <= in_funct7;
        s1_rd     <= in_rd;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_imm    <= in_imm;
      end
      if (in_start) begin
        // restart beats any write completing on this edge
        state     <= RUN;
        s1_valid  <= accept;
        out_we    <= 1'b0;
        out_addr  <= BASE;
        out_count <= '0;
        out_full  <= 1'b0;
        out_err   <= 1'b0;
      end else begin
        if (accept)
          s1_valid <= 1'b1;
        else if (s1_adv)
          s1_valid <= 1'b0;

        if (wr_done) begin
          out_addr  <= out_addr + 1'b1;
          out_count <= out_count + 1'b1;
          if (out_count == LAST) begin
            state    <= FULL;
            out_full <= 1'b1;
          end
        end

        if (s1_adv) begin
          if (enc_bad) begin
            out_we  <= 1'b0;
            out_err <= 1'b1;
          end else begin
            out_we   <= 1'b1;
            out_inst <= enc_inst;
          end
        end else if (wr_done) begin
          out_we <= 1'b0;
        end
      end
    end
  end

endmodule
